// File: rtl/my_chip.sv
// my_chip: multicycle 16-bit teaching processor.
// One shared 16-bit bus connects the instruction input, a 16-entry register
// file and an A/G accumulator pair feeding an add/subtract ALU.
// Instructions (load, mov, add, sub) are sequenced by a four-step control FSM
// (T0..T3). Immediate data for load arrives on INSTRUCTION in the step after
// the fetch. Reserved opcodes complete in two steps without a register write.
module my_chip (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] INSTRUCTION,
    output logic [15:0] BUS,
    output logic        DONE
);

    // Opcode encodings held in IR[10:8].
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;

    // Control steps; T0 is always the fetch.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t       step;
    step_t       step_next;

    logic [15:0] regs [16];
    logic [10:0] ir;
    logic [15:0] acc_a;
    logic [15:0] acc_g;

    // Decoded fields of the held instruction.
    logic [2:0]  opcode;
    logic [3:0]  rx;
    logic [3:0]  ry;

    // Per-step controls produced by the sequencer.
    logic        ir_load;
    logic        reg_write;
    logic        a_load;
    logic        g_load;
    logic [15:0] bus_value;
    logic        done_value;
    logic [15:0] alu_result;

    assign opcode = ir[10:8];
    assign rx     = ir[7:4];
    assign ry     = ir[3:0];

    // Step register: reset aborts any instruction and restarts at fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step <= T0;
        end else begin
            step <= step_next;
        end
    end

    // Next-step decode, bus source selection and register-enable generation.
    always_comb begin
        step_next  = T0;
        bus_value  = 16'h0000;
        done_value = 1'b0;
        ir_load    = 1'b0;
        reg_write  = 1'b0;
        a_load     = 1'b0;
        g_load     = 1'b0;
        unique case (step)
            T0: begin
                // Fetch: bus idles at zero while IR captures the word.
                ir_load   = 1'b1;
                step_next = T1;
            end
            T1: begin
                unique case (opcode)
                    OP_LOAD: begin
                        bus_value  = INSTRUCTION;
                        reg_write  = 1'b1;
                        done_value = 1'b1;
                        step_next  = T0;
                    end
                    OP_MOV: begin
                        bus_value  = regs[ry];
                        reg_write  = 1'b1;
                        done_value = 1'b1;
                        step_next  = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_value = regs[rx];
                        a_load    = 1'b1;
                        step_next = T2;
                    end
                    default: begin
                        // Reserved opcode: finish with no side effects.
                        done_value = 1'b1;
                        step_next  = T0;
                    end
                endcase
            end
            T2: begin
                bus_value = regs[ry];
                g_load    = 1'b1;
                step_next = T3;
            end
            T3: begin
                bus_value  = acc_g;
                reg_write  = 1'b1;
                done_value = 1'b1;
                step_next  = T0;
            end
            default: begin
                step_next = T0;
            end
        endcase
    end

    // ALU: only add and sub ever reach T2, so bit 0 of the opcode picks the
    // operation. Carry and borrow wrap modulo 2^16.
    always_comb begin
        if (opcode == OP_SUB) begin
            alu_result = acc_a - bus_value;
        end else begin
            alu_result = acc_a + bus_value;
        end
    end

    // Instruction register: captures the low 11 bits at fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= 11'h000;
        end else if (ir_load) begin
            ir <= INSTRUCTION[10:0];
        end
    end

    // Accumulator pair: A holds the first operand, G the ALU result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_a <= 16'h0000;
            acc_g <= 16'h0000;
        end else begin
            if (a_load) begin
                acc_a <= bus_value;
            end
            if (g_load) begin
                acc_g <= alu_result;
            end
        end
    end

    // Register file: single write port from the bus into Rx, no bypass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (reg_write) begin
            regs[rx] <= bus_value;
        end
    end

    assign BUS  = bus_value;
    assign DONE = done_value;

endmodule

// File: tb/tb_my_chip.sv
// Self-checking bench for my_chip. A driver issues instructions and pushes
// the expected per-step {DONE, BUS} pair; a monitor pops and compares on
// every falling edge. Register contents are read back through mov rk,rk.
module tb_my_chip;

    logic        clk;
    logic        reset;
    logic [15:0] INSTRUCTION;
    logic [15:0] BUS;
    logic        DONE;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    logic [16:0] exp_q [$];
    logic [15:0] model_r [16];

    my_chip dut (
        .clk        (clk),
        .reset      (reset),
        .INSTRUCTION(INSTRUCTION),
        .BUS        (BUS),
        .DONE       (DONE)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got done=%0b bus=%04h, expected done=%0b bus=%04h",
                     name, act[16], act[15:0], exp[16], exp[15:0]);
        end
    endtask

    // Monitor: one expected step per falling edge while out of reset.
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("step", {DONE, BUS}, e);
            end else begin
                check("idle_done", {DONE, BUS}, {1'b0, BUS});
            end
        end
    end

    function automatic logic [15:0] rnd16();
        return 16'($urandom_range(0, 65535));
    endfunction

    // Driver: issue one instruction starting in T0 (just after an edge).
    task automatic issue(input logic [2:0] op, input logic [3:0] rx,
                         input logic [3:0] ry, input logic [15:0] data);
        logic [4:0]  hi;
        logic [15:0] word;
        logic [15:0] res;
        int          n;
        hi   = 5'($urandom_range(0, 31));
        word = {hi, op, rx, ry};
        exp_q.push_back(17'h0);
        case (op)
            3'd0: begin
                exp_q.push_back({1'b1, data});
                model_r[rx] = data;
                n = 2;
            end
            3'd1: begin
                exp_q.push_back({1'b1, model_r[ry]});
                model_r[rx] = model_r[ry];
                n = 2;
            end
            3'd2, 3'd3: begin
                res = (op == 3'd2) ? 16'(model_r[rx] + model_r[ry])
                                   : 16'(model_r[rx] - model_r[ry]);
                exp_q.push_back({1'b0, model_r[rx]});
                exp_q.push_back({1'b0, model_r[ry]});
                exp_q.push_back({1'b1, res});
                model_r[rx] = res;
                n = 4;
            end
            default: begin
                exp_q.push_back({1'b1, 16'h0});
                n = 2;
            end
        endcase
        INSTRUCTION = word;
        @(posedge clk);
        #1;
        INSTRUCTION = (op == 3'd0) ? data : rnd16();
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            INSTRUCTION = rnd16();
        end
    endtask

    task automatic readback_all();
        for (int k = 0; k < 16; k++) begin
            issue(3'd1, 4'(k), 4'(k), 16'h0);
        end
    endtask

    initial begin
        logic [2:0] op;
        INSTRUCTION = 16'h0;
        reset = 1'b1;
        for (int k = 0; k < 16; k++) model_r[k] = 16'h0;

        // Asynchronous reset mid-clock
        #2;
        reset = 1'b0;
        #1;
        check("reset_outputs", {DONE, BUS}, 17'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed sequence from the plan
        issue(3'd0, 4'd1, 4'd0, 16'h0007);
        issue(3'd0, 4'd2, 4'd0, 16'h0008);
        issue(3'd1, 4'd3, 4'd2, 16'h0);
        issue(3'd2, 4'd3, 4'd1, 16'h0);
        issue(3'd3, 4'd1, 4'd2, 16'h0);
        issue(3'd1, 4'd4, 4'd1, 16'h0);
        issue(3'd0, 4'd5, 4'd0, 16'h8000);
        issue(3'd2, 4'd5, 4'd5, 16'h0);
        issue(3'd0, 4'd6, 4'd0, 16'h1234);
        issue(3'd3, 4'd6, 4'd6, 16'h0);
        issue(3'd7, 4'd2, 4'd1, 16'h0);
        issue(3'd4, 4'd9, 4'd9, 16'h0);
        readback_all();

        // Randomized instruction stream
        for (int t = 0; t < 300; t++) begin
            op = 3'($urandom_range(0, 7));
            issue(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rnd16());
        end
        readback_all();

        // Reset during add T2 aborts the instruction
        issue(3'd0, 4'd3, 4'd0, 16'h00AA);
        exp_q.push_back(17'h0);
        exp_q.push_back({1'b0, model_r[3]});
        INSTRUCTION = {5'b0, 3'd2, 4'd3, 4'd1};
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_in_t2", {DONE, BUS}, 17'h0);
        for (int k = 0; k < 16; k++) model_r[k] = 16'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        readback_all();

        @(posedge clk);
        #1;
        check("queue_drained", 17'(exp_q.size()), 17'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/my_chip.md
# my_chip

Minimal multicycle 16-bit processor core with a 16-entry register file, an A/G accumulator pair and an add/subtract ALU, all sharing one 16-bit internal bus. It executes load, move, add and subtract instructions supplied one word at a time on the `INSTRUCTION` input. A multi-step control FSM sequences each instruction. The block is the top level of the teaching datapath and has no memory interface: immediate data arrives on the same input as instructions.

## Interface
- No parameters. Data width is fixed at 16 bits, the register count at 16, and the instruction field width at 11 bits.
- Ports are listed in positional order; the first three are mandatory in this order.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. Low clears all state immediately.
- `INSTRUCTION`  input  16  instruction word, or immediate data word during the second step of `load`.
- `BUS`  output  16  value currently driven on the internal bus; used for observation and debug.
- `DONE`  output  1  high during the final step of each instruction.

## Operation
- Instruction word format:
  - `[15:11]` ignored.
  - `[10:8]` opcode.
  - `[7:4]` Rx, the destination and first operand.
  - `[3:0]` Ry, the second operand.
- Opcodes:
  - 000 `load`: Rx ← next `INSTRUCTION` word.
  - 001 `mov`: Rx ← Ry.
  - 010 `add`: Rx ← Rx + Ry.
  - 011 `sub`: Rx ← Rx − Ry.
  - 100–111: reserved, executed as a NOP.
- State: R0–R15 (16 bits each), IR (11 bits), A (16), G (16), and FSM step T0–T3. R0 is an ordinary writable register.
- FSM steps and bus source per instruction:
  - T0 (fetch): IR ← `INSTRUCTION[10:0]`; `BUS` = 0; always go to T1.
  - `load` T1: `BUS` = `INSTRUCTION`; Rx ← `BUS`; `DONE`=1; go to T0.
  - `mov` T1: `BUS` = Ry; Rx ← `BUS`; `DONE`=1; go to T0.
  - `add`/`sub` T1: `BUS` = Rx; A ← `BUS`; go to T2.
  - `add`/`sub` T2: `BUS` = Ry; G ← A ± `BUS`; go to T3.
  - `add`/`sub` T3: `BUS` = G; Rx ← `BUS`; `DONE`=1; go to T0.
  - Reserved opcode T1: `BUS` = 0; no register write; `DONE`=1; go to T0.
- Arithmetic is 16-bit modulo 2^16. Carry and borrow are discarded; no flags are kept.
- When Rx = Ry:
  - `mov` is a no-op write.
  - `add` doubles the register.
  - `sub` clears the register.
- The register file has no bypass. All reads in a step see the values from before that step's edge.

## Timing
- Reset (`reset`=0) forces the following at once, independent of `clk`:
  - R0–R15, IR, A and G to 0.
  - FSM to T0.
  - `BUS`=0 and `DONE`=0.
- Reset asserted mid-instruction aborts it. No partial write occurs after reset is asserted, and execution restarts at T0 after release.
- Latency in clocks, counting from the T0 fetch edge:
  - `load` and `mov`: 2 clocks; the destination is updated on the 2nd edge.
  - `add` and `sub`: 4 clocks; the destination is updated on the 4th edge.
  - Reserved opcodes: 2 clocks.
- `INSTRUCTION` is sampled only on rising edges, in T0 and in `load` T1.
- The environment holds each instruction word for one clock starting at T0. For `load`, it presents the data word during the following clock.
- `INSTRUCTION` values present during other steps are ignored. There is no handshake: the source must time words to the fixed latencies, using `DONE` as the end marker.
- `BUS` and `DONE` are combinational from the FSM state, IR, the registers and `INSTRUCTION`.

## Test plan
- Reset:
  - Drive `reset`=0 mid-clock → all registers read 0, `BUS`=0, `DONE`=0 immediately.
  - Release → first edge performs a fetch.
- Load:
  - `load` r1 with data 0x0007, then `load` r2 with data 0x0008 → r1=7 and r2=8 after 2 clocks each.
  - `DONE` is high in each T1.
  - `BUS` = 0x0007, then 0x0008, in those steps.
- Move:
  - `mov` r3,r2 → r3=8 after 2 clocks; r2 unchanged.
- Add:
  - `add` r3,r1 → `BUS` sequence 0, 8, 7, 15 over T0–T3.
  - r3=15 after the 4th edge; `DONE` is high only in T3.
- Subtract with wrap:
  - `sub` r1,r2 → r1=0xFFFF (7−8 wraps).
  - Then `mov` r4,r1 → r4=0xFFFF.
- Edge cases:
  - `add` r5,r5 with r5=0x8000 → 0x0000.
  - Opcode 111 → no register change, `DONE` after 2 clocks.
  - Reset asserted during `add` T2 → r3 unchanged (0 after reset), FSM at T0.
